// File: rtl/sdr_xfer_sequencer_if.sv
// sdr_xfer_sequencer_if: command, stream and SDRAM-bridge signals of the transfer sequencer.
interface sdr_xfer_sequencer_if #(
  parameter int WORD_W  = 32,
  parameter int NWORDS  = 64,
  parameter int ADDR_W  = 32,
  parameter int NELEM_W = 30
);
  logic                     cmd_start;
  logic                     cmd_write;
  logic [ADDR_W-1:0]        cmd_addr;
  logic [NELEM_W-1:0]       cmd_nelems;
  logic                     cmd_abort;
  logic                     busy;
  logic                     done;
  logic [7:0]               status;
  logic                     rd_valid;
  logic [WORD_W-1:0]        rd_data;
  logic                     rd_ready;
  logic                     wr_valid;
  logic [WORD_W-1:0]        wr_data;
  logic                     wr_ready;
  logic [ADDR_W-1:0]        sdr_baseaddr;
  logic [NELEM_W-1:0]       sdr_nelems;
  logic                     sdr_readstart;
  logic                     sdr_readend;
  logic [WORD_W*NWORDS-1:0] sdr_readdata;
  logic                     sdr_writestart;
  logic                     sdr_writeend;
  logic [WORD_W*NWORDS-1:0] sdr_writedata;
  modport slave (
    input  cmd_start, cmd_write, cmd_addr, cmd_nelems, cmd_abort, rd_ready, wr_valid, wr_data,
           sdr_readend, sdr_readdata, sdr_writeend,
    output busy, done, status, rd_valid, rd_data, wr_ready, sdr_baseaddr, sdr_nelems,
           sdr_readstart, sdr_writestart, sdr_writedata
  );
  modport master (
    output cmd_start, cmd_write, cmd_addr, cmd_nelems, cmd_abort, rd_ready, wr_valid, wr_data,
           sdr_readend, sdr_readdata, sdr_writeend,
    input  busy, done, status, rd_valid, rd_data, wr_ready, sdr_baseaddr, sdr_nelems,
           sdr_readstart, sdr_writestart, sdr_writedata
  );
endinterface

// File: rtl/sdr_xfer_sequencer.sv
// sdr_xfer_sequencer: one-burst read/write sequencer between a word stream and the HPS SDRAM bridge.
module sdr_xfer_sequencer #(
  parameter int WORD_W      = 32,
  parameter int NWORDS      = 64,
  parameter int ADDR_W      = 32,
  parameter int NELEM_W     = 30,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic                 sdr_clk,
  input logic                 sdr_reset_n,
  sdr_xfer_sequencer_if.slave bus
);
  localparam int IW = $clog2(NWORDS);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_STREAM, WR_FILL, WR_REQ, WR_WAIT, DONE} state_t;
  state_t                   state;
  logic [IW-1:0]            idx;
  logic [CW-1:0]            cnt;
  logic [WORD_W*NWORDS-1:0] rbuf;
  logic                     clip;
  logic                     abort;
  logic                     last;
  logic                     expired;
  logic [NELEM_W-1:0]       clen;
  logic [7:0]               ok;
  always_comb begin
    clen    = bus.cmd_nelems > NELEM_W'(NWORDS) ? NELEM_W'(NWORDS) : bus.cmd_nelems;
    abort   = bus.cmd_abort && state != IDLE && state != DONE;
    last    = NELEM_W'(idx) == bus.sdr_nelems - NELEM_W'(1);
    expired = cnt == CW'(TIMEOUT_CYC - 1);
    ok      = clip ? 8'h81 : 8'h01;
  end
  always_ff @(posedge sdr_clk) begin
    if (!sdr_reset_n) begin
      state              <= IDLE;
      idx                <= '0;
      cnt                <= '0;
      rbuf               <= '0;
      clip               <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.status         <= '0;
      bus.rd_valid       <= 1'b0;
      bus.rd_data        <= '0;
      bus.wr_ready       <= 1'b0;
      bus.sdr_baseaddr   <= '0;
      bus.sdr_nelems     <= '0;
      bus.sdr_readstart  <= 1'b0;
      bus.sdr_writestart <= 1'b0;
      bus.sdr_writedata  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_start) begin
          bus.sdr_baseaddr  <= bus.cmd_addr;
          bus.sdr_nelems    <= clen;
          clip              <= bus.cmd_nelems > NELEM_W'(NWORDS);
          bus.sdr_writedata <= '0;
          idx               <= '0;
          bus.busy          <= 1'b1;
          if (clen == '0) begin
            state      <= DONE;
            bus.done   <= 1'b1;
            bus.status <= 8'h03;
          end else if (bus.cmd_write) begin
            state        <= WR_FILL;
            bus.wr_ready <= 1'b1;
          end else begin
            state             <= RD_REQ;
            bus.sdr_readstart <= 1'b1;
          end
        end
        RD_REQ: begin
          bus.sdr_readstart <= 1'b0;
          cnt               <= '0;
          state             <= RD_WAIT;
        end
        RD_WAIT: if (bus.sdr_readend) begin
          rbuf         <= bus.sdr_readdata;
          bus.rd_data  <= bus.sdr_readdata[WORD_W-1:0];
          bus.rd_valid <= 1'b1;
          idx          <= '0;
          state        <= RD_STREAM;
        end else if (expired) begin
          state      <= DONE;
          bus.done   <= 1'b1;
          bus.status <= 8'h02;
        end else cnt <= cnt + CW'(1);
        // rd_valid is held high for the whole stream, so rd_ready alone completes a handshake
        RD_STREAM: if (bus.rd_ready) begin
          if (last) begin
            bus.rd_valid <= 1'b0;
            state        <= DONE;
            bus.done     <= 1'b1;
            bus.status   <= ok;
          end else begin
            idx         <= idx + IW'(1);
            bus.rd_data <= rbuf[int'(idx + IW'(1))*WORD_W +: WORD_W];
          end
        end
        WR_FILL: if (bus.wr_valid && !abort) begin
          bus.sdr_writedata[int'(idx)*WORD_W +: WORD_W] <= bus.wr_data;
          if (last) begin
            bus.wr_ready       <= 1'b0;
            bus.sdr_writestart <= 1'b1;
            state              <= WR_REQ;
          end else idx <= idx + IW'(1);
        end
        WR_REQ: begin
          bus.sdr_writestart <= 1'b0;
          cnt                <= '0;
          state              <= WR_WAIT;
        end
        WR_WAIT: if (bus.sdr_writeend) begin
          state      <= DONE;
          bus.done   <= 1'b1;
          bus.status <= ok;
        end else if (expired) begin
          state      <= DONE;
          bus.done   <= 1'b1;
          bus.status <= 8'h02;
        end else cnt <= cnt + CW'(1);
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // abort overrides whatever the case above decided this cycle
      if (abort) begin
        state              <= DONE;
        bus.done           <= 1'b1;
        bus.status         <= 8'h04;
        bus.sdr_readstart  <= 1'b0;
        bus.sdr_writestart <= 1'b0;
        bus.rd_valid       <= 1'b0;
        bus.wr_ready       <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sdr_xfer_sequencer.sv
// tb_sdr_xfer_sequencer: table-driven transactions plus reset sequences for the transfer sequencer.
module tb_sdr_xfer_sequencer;
  localparam int W = 32, N = 64, AW = 32, NW = 30, TO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sdr_xfer_sequencer_if #(.WORD_W(W), .NWORDS(N), .ADDR_W(AW), .NELEM_W(NW)) bus ();
  sdr_xfer_sequencer #(.WORD_W(W), .NWORDS(N), .ADDR_W(AW), .NELEM_W(NW), .TIMEOUT_CYC(TO)) dut (
    .sdr_clk(clk), .sdr_reset_n(rst_n), .bus(bus)
  );
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic       wr;
    int         n;
    int         dly;
    bit         rnd;
    int         abort_cyc;
    int         busy_cyc;
    logic [7:0] st;
    int         words;
    int         rs;
    int         ws;
    int         done_cyc;
  } vec_t;
  vec_t vt[14];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_wbuf(input string name, input logic [W*N-1:0] exp);
    int bad;
    bad = -1;
    for (int i = N - 1; i >= 0; i--) if (bus.sdr_writedata[i*W +: W] !== exp[i*W +: W]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: slot %0d got %0h expected %0h", name, bad, bus.sdr_writedata[bad*W +: W], exp[bad*W +: W]);
    end
  endtask
  task automatic idle_inputs();
    bus.cmd_start = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_nelems = '0; bus.cmd_abort = 0;
    bus.rd_ready = 0; bus.wr_valid = 0; bus.wr_data = '0; bus.sdr_readend = 0; bus.sdr_writeend = 0;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " done"}, bus.done, 0);
    chk({tag, " status"}, bus.status, 0);
    chk({tag, " rd_valid"}, bus.rd_valid, 0);
    chk({tag, " rd_data"}, bus.rd_data, 0);
    chk({tag, " wr_ready"}, bus.wr_ready, 0);
    chk({tag, " baseaddr"}, bus.sdr_baseaddr, 0);
    chk({tag, " nelems"}, bus.sdr_nelems, 0);
    chk({tag, " readstart"}, bus.sdr_readstart, 0);
    chk({tag, " writestart"}, bus.sdr_writestart, 0);
    chk({tag, " writedata"}, |bus.sdr_writedata, 0);
  endtask
  task automatic run_vec(input vec_t v, input int id);
    int cyc, k, rs, ws, rs_cyc, endat, done_at, len;
    logic [W*N-1:0] rdat, wexp;
    logic [W-1:0] wd[N];
    logic pv, pr, ab;
    logic [W-1:0] pd;
    logic [AW-1:0] addr;
    string t;
    t = $sformatf("v%0d", id);
    len = v.n > N ? N : v.n;
    addr = 32'h1000_0000 + 32'(id) * 32'h100;
    for (int i = 0; i < N; i++) begin
      rdat[i*W +: W] = 32'hA000 + 32'(i);
      wd[i] = 32'h5000 + 32'(i);
    end
    wd[0] = 32'hDEADBEEF; wd[1] = 32'hBEEFD00D; wd[2] = 32'h12345678;
    wexp = '0; endat = -1; done_at = -1; rs_cyc = -1; k = 0; rs = 0; ws = 0; pv = 0; pr = 0; pd = '0;
    @(negedge clk);
    bus.cmd_start = 1; bus.cmd_write = v.wr; bus.cmd_addr = addr; bus.cmd_nelems = NW'(v.n);
    bus.sdr_readdata = rdat;
    cyc = 0;
    while (done_at < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({t, " busy"}, bus.busy, 1);
      if (bus.done) done_at = cyc;
      else begin
        bus.cmd_start = (cyc == v.busy_cyc);
        bus.cmd_write = (cyc == v.busy_cyc) ? ~v.wr : v.wr;
        bus.cmd_nelems = (cyc == v.busy_cyc) ? '0 : NW'(v.n);
        if (bus.sdr_readstart) begin
          rs++;
          if (rs_cyc < 0) rs_cyc = cyc;
          if (v.dly > 0) endat = cyc + v.dly;
        end
        if (bus.sdr_writestart) begin
          ws++;
          if (v.dly > 0) endat = cyc + v.dly;
        end
        bus.sdr_readend = (cyc == endat) && !v.wr;
        bus.sdr_writeend = (cyc == endat) && v.wr;
        ab = (cyc == v.abort_cyc);
        bus.cmd_abort = ab;
        if (pv && !pr && bus.rd_valid) chk({t, " rd_data hold"}, bus.rd_data, pd);
        bus.rd_ready = v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (bus.rd_valid && bus.rd_ready && !ab) begin
          chk($sformatf("%s word%0d", t, k), bus.rd_data, 32'hA000 + 32'(k));
          k++;
        end
        pv = bus.rd_valid; pr = bus.rd_ready; pd = bus.rd_data;
        bus.wr_valid = v.wr && k < len && (v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
        bus.wr_data = wd[k < N ? k : 0];
        if (bus.wr_valid && bus.wr_ready && !ab) begin
          wexp[k*W +: W] = wd[k];
          k++;
        end
      end
    end
    idle_inputs();
    chk({t, " done seen"}, done_at >= 0, 1);
    if (v.done_cyc >= 0) chk({t, " done cycle"}, 64'(done_at), 64'(v.done_cyc));
    if (v.rs > 0) chk({t, " readstart latency"}, 64'(rs_cyc), 1);
    chk({t, " status"}, bus.status, v.st);
    chk({t, " words"}, 64'(k), 64'(v.words));
    chk({t, " readstarts"}, 64'(rs), 64'(v.rs));
    chk({t, " writestarts"}, 64'(ws), 64'(v.ws));
    chk({t, " rd_valid at done"}, bus.rd_valid, 0);
    chk({t, " wr_ready at done"}, bus.wr_ready, 0);
    chk({t, " sdr_nelems"}, bus.sdr_nelems, 64'(len));
    chk({t, " baseaddr"}, bus.sdr_baseaddr, addr);
    chk_wbuf({t, " writedata"}, wexp);
    @(negedge clk);
    chk({t, " done 1 cycle"}, bus.done, 0);
    chk({t, " idle busy"}, bus.busy, 0);
    chk({t, " status held"}, bus.status, v.st);
  endtask
  initial begin
    logic seen;
    vt[0]  = '{1'b0, 15,  5, 1'b0,  0, 0, 8'h01, 15, 1, 0, 22};
    vt[1]  = '{1'b0, 100, 3, 1'b1,  0, 0, 8'h81, 64, 1, 0, -1};
    vt[2]  = '{1'b1, 3,   2, 1'b0,  0, 0, 8'h01,  3, 0, 1,  7};
    vt[3]  = '{1'b0, 4,   0, 1'b0,  0, 0, 8'h02,  0, 1, 0, 18};
    vt[4]  = '{1'b0, 4,  16, 1'b0,  0, 0, 8'h01,  4, 1, 0, 22};
    vt[5]  = '{1'b0, 4,  17, 1'b0,  0, 0, 8'h02,  0, 1, 0, 18};
    vt[6]  = '{1'b0, 0,   3, 1'b0,  0, 0, 8'h03,  0, 0, 0,  1};
    vt[7]  = '{1'b0, 15,  5, 1'b0, 10, 0, 8'h04,  3, 1, 0, 11};
    vt[8]  = '{1'b1, 8,   2, 1'b0,  3, 0, 8'h04,  2, 0, 0,  4};
    vt[9]  = '{1'b0, 2,   3, 1'b0,  0, 4, 8'h01,  2, 1, 0,  7};
    vt[10] = '{1'b1, 0,   2, 1'b0,  0, 0, 8'h03,  0, 0, 0,  1};
    vt[11] = '{1'b1, 70,  1, 1'b1,  0, 0, 8'h81, 64, 0, 1, -1};
    vt[12] = '{1'b1, 64,  1, 1'b0,  0, 0, 8'h01, 64, 0, 1, 67};
    vt[13] = '{1'b1, 1,   0, 1'b0,  0, 0, 8'h02,  1, 0, 1, 19};
    idle_inputs();
    bus.sdr_readdata = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    for (int i = 0; i < 14; i++) run_vec(vt[i], i);
    // reset while waiting for writeend drops the transaction silently
    @(negedge clk);
    bus.cmd_start = 1; bus.cmd_write = 1; bus.cmd_addr = 32'h2000; bus.cmd_nelems = 1;
    @(negedge clk);
    bus.cmd_start = 0; bus.wr_valid = 1; bus.wr_data = 32'hCAFE0001;
    chk("rst seq wr_ready", bus.wr_ready, 1);
    @(negedge clk);
    bus.wr_valid = 0;
    chk("rst seq writestart", bus.sdr_writestart, 1);
    @(negedge clk);
    chk("rst seq waiting", bus.busy, 1);
    chk("rst seq slot0", bus.sdr_writedata[W-1:0], 32'hCAFE0001);
    rst_n = 0;
    @(negedge clk);
    check_zero("rst mid");
    rst_n = 1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen |= bus.done | bus.busy;
    end
    chk("rst no done", seen, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
